// File: rtl/uart_rx_fifo_writer.sv
// 8N1 UART receiver that pushes each good byte into a downstream 8-deep FIFO.
// Framing errors pulse frame_err; bytes that arrive while the FIFO is full set a sticky overflow.
module uart_rx_fifo_writer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       fifo_full,
  output logic       fifo_wr_en,
  output logic [7:0] fifo_data,
  output logic       overflow,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] PUSH      = 3'd4;
  localparam logic [2:0] WAIT_HIGH = 3'd5;

  logic             rx_p0;
  logic             rx_s;
  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             push_second;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0       <= 1'b1;
      rx_s        <= 1'b1;
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'h00;
      push_second <= 1'b0;
      fifo_wr_en  <= 1'b0;
      fifo_data   <= 8'h00;
      overflow    <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      // Synchronizer stage boundary: rx -> rx_p0 -> rx_s
      rx_p0     <= rx;
      rx_s      <= rx_p0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end

        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        STOP: begin
          if (cnt == CNT_FULL) begin
            cnt <= '0;
            if (!rx_s) begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end else if (fifo_full) begin
              overflow <= 1'b1;
              state    <= IDLE;
            end else begin
              fifo_data   <= shreg;
              fifo_wr_en  <= 1'b1;
              push_second <= 1'b0;
              state       <= PUSH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Two-cycle strobe: the FIFO may be busy with a read in either one.
        PUSH: begin
          if (push_second) begin
            fifo_wr_en <= 1'b0;
            state      <= IDLE;
          end else begin
            push_second <= 1'b1;
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          fifo_wr_en <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Directed bench for uart_rx_fifo_writer at 8 clocks per bit, with a FIFO model
// that accepts writes only on alternate cycles, as if a reader were popping continuously.
module tb_uart_rx_fifo_writer;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       fifo_full = 1'b0;
  logic       fifo_wr_en;
  logic [7:0] fifo_data;
  logic       overflow;
  logic       frame_err;
  logic       busy;

  uart_rx_fifo_writer #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_data  (fifo_data),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         wr_cycles = 0;
  int         wr_run = 0;
  int         max_run = 0;
  int         last_rise_cyc = 0;
  int         fe_cycles = 0;
  int         busy_cycles = 0;
  logic       rd_phase = 1'b0;
  logic       accepted = 1'b0;
  logic [7:0] got[$];

  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_cycles = wr_cycles + 1;
      wr_run = wr_run + 1;
      if (wr_run > max_run) max_run = wr_run;
      if (wr_run == 1) last_rise_cyc = cyc;
      if (!rd_phase && !accepted) begin
        got.push_back(fifo_data);
        accepted = 1'b1;
      end
    end else begin
      wr_run = 0;
      accepted = 1'b0;
    end
    if (frame_err) fe_cycles = fe_cycles + 1;
    if (busy) busy_cycles = busy_cycles + 1;
    rd_phase = ~rd_phase;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int c0 = 0;

  // Caller must be 1 time unit after a rising edge; frames sent back to back have no gap.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    c0 = cyc;
    for (int i = 0; i < nbits; i++) begin
      rx = bits[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int w0, g0, fe0, b0;
  logic [7:0] byte_v;

  initial begin
    idle(3);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("rst_data", 32'(fifo_data), 32'h00);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(5);

    // Single good frame 0xA5
    w0 = wr_cycles; g0 = got.size(); fe0 = fe_cycles;
    send_frame(8'hA5, 1'b1, 10);
    idle(5);
    chk("a5_latency", 32'(last_rise_cyc - c0), 32'd79);
    chk("a5_wr_cycles", 32'(wr_cycles - w0), 32'd2);
    chk("a5_max_run", 32'(max_run), 32'd2);
    chk("a5_fifo_count", 32'(got.size() - g0), 32'd1);
    byte_v = got[g0];
    chk("a5_fifo_byte", 32'(byte_v), 32'hA5);
    chk("a5_data_hold", 32'(fifo_data), 32'hA5);
    chk("a5_overflow", 32'(overflow), 32'd0);
    chk("a5_frame_err", 32'(fe_cycles - fe0), 32'd0);
    chk("a5_busy", 32'(busy), 32'd0);

    // Back-to-back 0x01, 0xFF
    w0 = wr_cycles; g0 = got.size();
    send_frame(8'h01, 1'b1, 10);
    send_frame(8'hFF, 1'b1, 10);
    idle(10);
    chk("b2b_count", 32'(got.size() - g0), 32'd2);
    byte_v = got[g0];
    chk("b2b_first", 32'(byte_v), 32'h01);
    byte_v = got[g0 + 1];
    chk("b2b_second", 32'(byte_v), 32'hFF);
    chk("b2b_wr_cycles", 32'(wr_cycles - w0), 32'd4);
    chk("b2b_max_run", 32'(max_run), 32'd2);

    // Overflow with FIFO full
    fifo_full = 1'b1;
    w0 = wr_cycles; g0 = got.size();
    send_frame(8'h3C, 1'b1, 10);
    idle(10);
    chk("ovf_no_write", 32'(wr_cycles - w0), 32'd0);
    chk("ovf_set", 32'(overflow), 32'd1);
    fifo_full = 1'b0;
    send_frame(8'h5A, 1'b1, 10);
    idle(10);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    chk("ovf_next_count", 32'(got.size() - g0), 32'd1);
    byte_v = got[g0];
    chk("ovf_next_byte", 32'(byte_v), 32'h5A);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk("ovf_cleared", 32'(overflow), 32'd0);
    idle(5);

    // False start: rx low for 2 cycles
    w0 = wr_cycles; fe0 = fe_cycles; b0 = busy_cycles;
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(20);
    chk("fs_busy_cycles", 32'(busy_cycles - b0), 32'd4);
    chk("fs_no_write", 32'(wr_cycles - w0), 32'd0);
    chk("fs_no_frame_err", 32'(fe_cycles - fe0), 32'd0);
    chk("fs_idle", 32'(busy), 32'd0);

    // Framing error followed by a long break
    w0 = wr_cycles; fe0 = fe_cycles;
    send_frame(8'h55, 1'b0, 10);
    idle(40);
    chk("fe_wait_busy", 32'(busy), 32'd1);
    chk("fe_pulse", 32'(fe_cycles - fe0), 32'd1);
    chk("fe_frame_err_low", 32'(frame_err), 32'd0);
    rx = 1'b1;
    idle(10);
    chk("fe_back_idle", 32'(busy), 32'd0);
    chk("fe_single_pulse", 32'(fe_cycles - fe0), 32'd1);
    chk("fe_no_write", 32'(wr_cycles - w0), 32'd0);

    // Reset during data bit 4
    send_frame(8'h99, 1'b1, 5);
    rx = 1'b1;
    idle(4);
    chk("mid_busy_before", 32'(busy), 32'd1);
    w0 = wr_cycles;
    reset = 1'b1;
    idle(1);
    chk("mid_wr_en", 32'(fifo_wr_en), 32'd0);
    chk("mid_data", 32'(fifo_data), 32'h00);
    chk("mid_overflow", 32'(overflow), 32'd0);
    chk("mid_frame_err", 32'(frame_err), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(30);
    chk("mid_no_write", 32'(wr_cycles - w0), 32'd0);
    g0 = got.size();
    send_frame(8'h81, 1'b1, 10);
    idle(10);
    chk("post_count", 32'(got.size() - g0), 32'd1);
    byte_v = got[g0];
    chk("post_byte", 32'(byte_v), 32'h81);
    chk("post_data", 32'(fifo_data), 32'h81);
    chk("post_wr_cycles", 32'(wr_cycles - w0), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_rx_fifo_writer.md
Name: uart_rx_fifo_writer

Overview:
UART receiver front-end that deserializes an asynchronous 8N1 serial line and pushes each good byte into the 8-deep byte FIFO directly downstream. It drives that FIFO's write port (wr_en / data_in) and observes its full flag. Framing errors and overflow drops are flagged, never written.

Parameters:
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range is integers >= 8.

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line; idles high
fifo_full  input  1  downstream FIFO full flag
fifo_wr_en  output  1  write strobe to downstream FIFO
fifo_data  output  8  byte to downstream FIFO data_in
overflow  output  1  sticky: a good byte was dropped because fifo_full=1
frame_err  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset:
  - state=IDLE; fifo_wr_en=0, fifo_data=0x00, overflow=0, frame_err=0, busy=0.
  - Synchronizer flops and the shift register reset to 1 and 0x00 respectively.
  - Reset asserted mid-frame aborts the frame; no write occurs.
- Synchronization:
  - rx passes through a 2-flop synchronizer to give rx_s.
  - All decisions use rx_s only.
- Bit counter: counts clk cycles within a bit. Bit index: 0..7.
- FSM states: IDLE, START, DATA, STOP, PUSH, WAIT_HIGH.
  - IDLE: when rx_s=0, go to START and clear the counter.
  - START: at counter = CLKS_PER_BIT/2-1 (integer divide), sample rx_s.
    - rx_s=0: go to DATA; clear the counter and the bit index.
    - rx_s=1: false start; return to IDLE with no flags.
  - DATA: at every counter = CLKS_PER_BIT-1, shift rx_s into the shift register, LSB first.
    - After bit 7 is sampled, go to STOP.
  - STOP: at counter = CLKS_PER_BIT-1, sample rx_s.
    - rx_s=1 and fifo_full=0: go to PUSH.
    - rx_s=1 and fifo_full=1: set overflow; go to IDLE; no write.
    - rx_s=0: pulse frame_err for 1 cycle; go to WAIT_HIGH; no write.
  - WAIT_HIGH: stay until rx_s=1, then go to IDLE. This prevents a break condition from retriggering reception.
  - PUSH: lasts exactly 2 cycles with fifo_wr_en=1, then go to IDLE.
- Write handshake:
  - The FIFO accepts a write only while in its own idle state. It may be busy with a read in any given cycle.
  - Holding fifo_wr_en for 2 consecutive cycles guarantees exactly one accepted write.
  - fifo_wr_en is never asserted for more than 2 consecutive cycles.
  - Consecutive PUSH windows are separated by at least 8 bit-times.
- Data stability:
  - fifo_data is loaded from the shift register on the edge entering PUSH.
  - It then holds unchanged until the next entry to PUSH.
  - This keeps data stable through the FIFO's write cycle, which follows acceptance.
- Latency: fifo_wr_en and fifo_data become valid on the clk edge after the stop-bit sample edge.
- fifo_full sampling:
  - fifo_full is sampled only at the stop-bit decision.
  - A stale full from a read in flight produces a conservative drop, flagged as overflow.
- overflow is cleared only by reset. frame_err is a pulse and is not sticky.
- Sampling point: rx_s is sampled mid-bit, with each data/stop sample CLKS_PER_BIT cycles after the start midpoint.

Test Plan:
- CLKS_PER_BIT=8; send 0xA5 8N1 -> fifo_wr_en high exactly 2 cycles, fifo_data=0xA5, FIFO count=1, overflow=0, frame_err=0.
- Back-to-back frames 0x01 then 0xFF with no idle gap, real FIFO attached, a reader popping continuously -> FIFO receives exactly 0x01 then 0xFF, no loss or duplicate.
- fifo_full=1, send 0x3C -> fifo_wr_en never asserted; overflow=1 and remains 1 after further good frames; reset clears it to 0.
- rx low for 2 cycles, then high -> busy pulses, no write, no frame_err, FSM back in IDLE.
- Frame 0x55 with stop bit 0, rx held low 40 cycles, then high -> single-cycle frame_err, no write, no new frame started until rx returns high.
- Reset asserted during DATA bit 4 -> next cycle all outputs 0, busy=0; a subsequent 0x81 frame is received correctly.
